text_cursor_scheduler: RTL

Sequences glyph draws for the text console. It sits between the keyboard/scan-code-to-ASCII path and the glyph renderer (pixel counter, glyph shifter and plot path).
- Buffers incoming ASCII codes and tracks the cursor cell.
- Interprets control codes (CR, backspace).
- Issues one draw/erase command per cell to the renderer over a req/done handshake.
- Clears the next row when the cursor wraps from the bottom of the screen.

---
 rtl/notepad_pkg.sv | 26 ++
 rtl/char_fifo.sv | 48 ++++
 rtl/text_cursor_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/notepad_pkg.sv
// Shared constants for the text console: screen geometry, ASCII control codes and
// the cursor scheduler state encoding.
package notepad_pkg;

  localparam int DEF_COLS = 40;
  localparam int DEF_ROWS = 15;
  localparam int COL_W    = 6;
  localparam int ROW_W    = 4;

  localparam logic [6:0] ASCII_BS    = 7'h08;
  localparam logic [6:0] ASCII_TAB   = 7'h09;
  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_DEL   = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DECODE     = 3'd1,
    S_DRAW       = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_ADVANCE    = 3'd4,
    S_CLEAR_ROW  = 3'd5,
    S_CLEAR_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/char_fifo.sv
// Small keystroke buffer (7-bit ASCII). DEPTH must be a power of two; a push while
// full is accepted only when a pop frees a slot in the same cycle.
module char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [6:0] din,
  output logic       full,
  output logic       empty,
  output logic [6:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/text_cursor_scheduler.sv
// Keystroke-to-renderer sequencer: buffers ASCII codes, tracks the cursor and issues one
// draw/erase per cell. Define TAB_EXPAND_EN to expand TAB into erases up to the next 8-column stop.
module text_cursor_scheduler
  import notepad_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             char_valid,
  input  logic [6:0]       char_code,
  output logic             draw_req,
  output logic [COL_W-1:0] draw_col,
  output logic [ROW_W-1:0] draw_row,
  output logic [6:0]       draw_code,
  output logic             draw_erase,
  input  logic             draw_done,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             busy,
  output logic             overflow
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t           state, state_d;
  logic [6:0]       cur_char, cur_char_d;
  logic [COL_W-1:0] col_d, clr_cnt, clr_cnt_d, dcol_d;
  logic [ROW_W-1:0] row_d, drow_d, row_next;
  logic [6:0]       dcode_d;
  logic             derase_d, req_d, tab_active, tab_active_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [6:0]       fifo_dout;

  char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (char_valid),
    .pop   (fifo_pop),
    .din   (char_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign row_next = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_W'(1);
  assign busy     = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    cur_char_d   = cur_char;
    col_d        = cursor_col;
    row_d        = cursor_row;
    clr_cnt_d    = clr_cnt;
    dcol_d       = draw_col;
    drow_d       = draw_row;
    dcode_d      = draw_code;
    derase_d     = draw_erase;
    req_d        = draw_req;
    tab_active_d = tab_active;
    fifo_pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_char_d = fifo_dout;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (cur_char >= ASCII_SPACE && cur_char < ASCII_DEL) begin
          dcol_d   = cursor_col;
          drow_d   = cursor_row;
          dcode_d  = cur_char;
          derase_d = 1'b0;
          state_d  = S_DRAW;
        end else if (cur_char == ASCII_CR) begin
          col_d     = '0;
          row_d     = row_next;
          clr_cnt_d = '0;
          state_d   = S_CLEAR_ROW;
        end else if (cur_char == ASCII_BS) begin
          if (cursor_col != '0) begin
            col_d   = cursor_col - COL_W'(1);
            state_d = S_DRAW;
          end else if (cursor_row != '0) begin
            col_d   = COL_LAST;
            row_d   = cursor_row - ROW_W'(1);
            state_d = S_DRAW;
          end
          dcol_d   = col_d;
          drow_d   = row_d;
          dcode_d  = ASCII_SPACE;
          derase_d = 1'b1;
`ifdef TAB_EXPAND_EN
        end else if (cur_char == ASCII_TAB) begin
          dcol_d       = cursor_col;
          drow_d       = cursor_row;
          dcode_d      = ASCII_SPACE;
          derase_d     = 1'b1;
          tab_active_d = 1'b1;
          state_d      = S_DRAW;
`endif
        end
      end
      S_DRAW: begin
        req_d   = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (draw_done) begin
          req_d   = 1'b0;
          state_d = (draw_erase && !tab_active) ? S_IDLE : S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        state_d      = S_IDLE;
        tab_active_d = 1'b0;
        if (cursor_col == COL_LAST) begin
          col_d     = '0;
          row_d     = row_next;
          clr_cnt_d = '0;
          state_d   = S_CLEAR_ROW;
        end else begin
          col_d = cursor_col + COL_W'(1);
          // a TAB keeps erasing until the cursor lands on an 8-column stop
          if (tab_active && col_d[2:0] != 3'd0) begin
            tab_active_d = 1'b1;
            dcol_d       = col_d;
            drow_d       = cursor_row;
            dcode_d      = ASCII_SPACE;
            derase_d     = 1'b1;
            state_d      = S_DRAW;
          end
        end
      end
      S_CLEAR_ROW: begin
        dcol_d   = clr_cnt;
        drow_d   = cursor_row;
        dcode_d  = ASCII_SPACE;
        derase_d = 1'b1;
        req_d    = 1'b1;
        state_d  = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: begin
        if (draw_done) begin
          req_d = 1'b0;
          if (clr_cnt == COL_LAST) begin
            clr_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            clr_cnt_d = clr_cnt + COL_W'(1);
            state_d   = S_CLEAR_ROW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_char   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      clr_cnt    <= '0;
      draw_col   <= '0;
      draw_row   <= '0;
      draw_code  <= '0;
      draw_erase <= 1'b0;
      draw_req   <= 1'b0;
      tab_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cur_char   <= cur_char_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
      clr_cnt    <= clr_cnt_d;
      draw_col   <= dcol_d;
      draw_row   <= drow_d;
      draw_code  <= dcode_d;
      draw_erase <= derase_d;
      draw_req   <= req_d;
      tab_active <= tab_active_d;
      if (char_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

endmodule
